// File: rtl/moving_average.sv
// moving_average: boxcar low-pass filter over the last 2^LOG2_TAPS accepted
// samples. A running sum is updated per accepted sample and divided by the
// window length with an arithmetic shift, which rounds toward minus infinity.
// Slots not yet written since reset count as zero, tracked by a fill counter,
// so the sample buffer never needs clearing.
module moving_average #(
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_TAPS  = 3
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_valid,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic                         o_valid,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_filled
);

  localparam int N_TAPS = 1 << LOG2_TAPS;
  localparam int SUM_W  = DATA_WIDTH + LOG2_TAPS;
  localparam int CNT_W  = LOG2_TAPS + 1;
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(N_TAPS - 1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic                          w_in_run;

  logic [CNT_W-1:0]              r_fill_cnt;
  logic [LOG2_TAPS-1:0]          r_wr_ptr;
  logic [LOG2_TAPS-1:0]          w_rd_addr;
  logic signed [SUM_W-1:0]       r_sum;
  logic signed [SUM_W-1:0]       w_sum_next;
  logic signed [SUM_W-1:0]       w_in_ext;
  logic signed [SUM_W-1:0]       w_old_ext;
  logic signed [DATA_WIDTH-1:0]  w_oldest;
  logic                          w_accept;

  logic signed [DATA_WIDTH-1:0]  r_mem [N_TAPS];
  logic signed [DATA_WIDTH-1:0]  r_rd_data;

  logic                          r_valid;
  logic signed [DATA_WIDTH-1:0]  r_data;
  logic                          r_filled;

  // A sample is taken only when valid and not swallowed by reset.
  assign w_accept = i_valid & ~i_reset;

  // State register: FILL until the window has seen N samples, then RUN.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: the accept that completes the window moves FILL to RUN;
  // RUN is held until reset.
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_FILL && w_accept && r_fill_cnt == FILL_LAST) begin
      w_state_next = ST_RUN;
    end
  end

  // FSM outputs: in RUN the buffer slot being overwritten holds a real sample.
  always_comb begin
    w_in_run = (r_state == ST_RUN);
  end

  // Fill counter advances only while filling and freezes once in RUN.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fill_cnt <= '0;
    end else if (w_accept && !w_in_run) begin
      r_fill_cnt <= r_fill_cnt + 1'b1;
    end
  end

  // The read address is prefetched: after an accept the slot that will be
  // evicted next is wr_ptr+1, so the registered read always presents the
  // oldest sample by the time the next accept arrives. The read and write
  // addresses in any one cycle never coincide.
  always_comb begin
    w_rd_addr = r_wr_ptr;
    if (i_reset) begin
      w_rd_addr = '0;
    end else if (w_accept) begin
      w_rd_addr = r_wr_ptr + 1'b1;
    end
  end

  // Sample buffer with registered read; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= i_data;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  // Running-sum update: add the new sample, drop the evicted one. While
  // filling the evicted slot is treated as zero. Intermediate wrap in the
  // modular add/subtract cancels because the result is a true window sum.
  always_comb begin
    w_oldest   = w_in_run ? r_rd_data : '0;
    w_in_ext   = {{LOG2_TAPS{i_data[DATA_WIDTH-1]}}, i_data};
    w_old_ext  = {{LOG2_TAPS{w_oldest[DATA_WIDTH-1]}}, w_oldest};
    w_sum_next = r_sum + w_in_ext - w_old_ext;
  end

  // Datapath registers: sum, pointer and the averaged output sample.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sum    <= '0;
      r_wr_ptr <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_filled <= 1'b0;
    end else begin
      r_valid  <= w_accept;
      r_filled <= (w_state_next == ST_RUN);
      if (w_accept) begin
        r_sum    <= w_sum_next;
        r_wr_ptr <= r_wr_ptr + 1'b1;
        // Dropping the low LOG2_TAPS bits is the floor divide by N.
        r_data   <= w_sum_next[SUM_W-1:LOG2_TAPS];
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_data   = r_data;
  assign o_filled = r_filled;

endmodule

// File: tb/tb_moving_average.sv
// Testbench for moving_average: a window-of-samples reference model checked
// against the outputs every cycle, plus directed vectors with literal values.
module tb_moving_average;

  localparam int DW = 8;
  localparam int LT = 3;
  localparam int N  = 1 << LT;

  logic                 clk;
  logic                 i_reset;
  logic                 i_valid;
  logic signed [DW-1:0] i_data;
  logic                 o_valid;
  logic signed [DW-1:0] o_data;
  logic                 o_filled;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int  hist[$];
  int  acc_cnt   = 0;
  int  exp_data  = 0;
  bit  exp_valid = 0;
  bit  exp_filled = 0;
  bit  model_live = 0;

  moving_average #(.DATA_WIDTH(DW), .LOG2_TAPS(LT)) dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_filled(o_filled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  function automatic int floor_div(input int num, input int den);
    int q;
    q = num / den;
    if (num < 0 && (num % den) != 0) q = q - 1;
    return q;
  endfunction

  // Model: average of the last N accepted samples (missing ones are zero),
  // floor-divided by N; compared against the DUT on every falling edge.
  always begin
    @(posedge clk);
    if (i_reset) begin
      hist.delete();
      acc_cnt    = 0;
      exp_data   = 0;
      exp_valid  = 0;
      exp_filled = 0;
      model_live = 1;
    end else if (i_valid) begin
      int s;
      hist.push_back(int'(i_data));
      if (hist.size() > N) void'(hist.pop_front());
      s = 0;
      foreach (hist[k]) s += hist[k];
      exp_data  = floor_div(s, N);
      exp_valid = 1;
      acc_cnt++;
      exp_filled = (acc_cnt >= N);
    end else begin
      exp_valid = 0;
    end
    @(negedge clk);
    if (model_live) begin
      chk("cyc_valid",  int'(o_valid),  int'(exp_valid));
      chk("cyc_data",   int'(o_data),   exp_data);
      chk("cyc_filled", int'(o_filled), int'(exp_filled));
    end
  end

  // Present one sample for one edge; check the pulse and value 1 cycle later.
  task automatic accept_chk(input int d, input int exp_d, input int exp_f, input string tag);
    @(negedge clk);
    i_reset = 1'b0;
    i_valid = 1'b1;
    i_data  = DW'(d);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    chk({tag, "_valid"},  int'(o_valid),  1);
    chk({tag, "_data"},   int'(o_data),   exp_d);
    chk({tag, "_model"},  exp_data,       exp_d);
    if (exp_f >= 0) chk({tag, "_filled"}, int'(o_filled), exp_f);
  endtask

  task automatic accept_only(input int d);
    @(negedge clk);
    i_reset = 1'b0;
    i_valid = 1'b1;
    i_data  = DW'(d);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  // Idle cycles; o_valid must be low and o_data held.
  task automatic idle_chk(input int k, input int held, input string tag);
    repeat (k) begin
      @(negedge clk);
      i_valid = 1'b0;
      i_reset = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_idle_valid"}, int'(o_valid), 0);
      chk({tag, "_idle_hold"},  int'(o_data),  held);
    end
  endtask

  task automatic do_reset(input logic v, input int d, input string tag);
    @(negedge clk);
    i_reset = 1'b1;
    i_valid = v;
    i_data  = DW'(d);
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    i_valid = 1'b0;
    chk({tag, "_rst_data"},   int'(o_data),   0);
    chk({tag, "_rst_valid"},  int'(o_valid),  0);
    chk({tag, "_rst_filled"}, int'(o_filled), 0);
  endtask

  initial begin
    int warm[8]  = '{2, 4, 6, 8, 10, 12, 14, 16};
    int stepv[8] = '{12, 8, 4, 0, -4, -8, -12, -16};
    int rst8[8]  = '{1, 2, 3, 4, 5, 6, 7, 8};

    i_reset = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    repeat (2) @(posedge clk);
    do_reset(1'b0, 0, "init");

    // Warm-up
    for (int i = 0; i < 8; i++)
      accept_chk(16, warm[i], (i == 7) ? 1 : 0, $sformatf("warm%0d", i));

    // Step response
    for (int i = 0; i < 8; i++)
      accept_chk(-16, stepv[i], 1, $sformatf("step%0d", i));

    // Extremes
    for (int i = 0; i < 7; i++) accept_only(127);
    accept_chk(127, 127, 1, "max_final");
    for (int i = 0; i < 7; i++) accept_only(-128);
    accept_chk(-128, -128, 1, "min_final");

    // Floor rounding
    do_reset(1'b0, 0, "floor");
    accept_chk(-1, -1, 0, "floor_m1");
    accept_chk(7, 0, 0, "floor_p7");

    // Gapped valid: one accept in three cycles
    do_reset(1'b0, 0, "gap");
    for (int i = 0; i < 8; i++) begin
      accept_chk(16, warm[i], (i == 7) ? 1 : 0, $sformatf("gap%0d", i));
      idle_chk(2, warm[i], $sformatf("gap%0d", i));
    end

    // Reset mid-run with a sample that must be discarded
    do_reset(1'b0, 0, "mid");
    for (int i = 0; i < 5; i++) accept_only(100);
    chk("mid_pre_data", int'(o_data), 62);
    do_reset(1'b1, 50, "midrst");
    for (int i = 0; i < 8; i++)
      accept_chk(8, rst8[i], (i == 7) ? 1 : 0, $sformatf("post%0d", i));

    idle_chk(3, 8, "tail");
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/moving_average.md
Name: moving_average

Overview:
- Boxcar moving-average low-pass stage that sits directly downstream of the gain stage and consumes its 8-bit output samples.
- Keeps a circular buffer of the last 2^LOG2_TAPS accepted samples and a running sum.
- Emits sum / 2^LOG2_TAPS with a one-cycle valid pulse per accepted sample.
- Gives the gain-to-filter chain a smoothing stage with explicit sample qualification.

Parameters:
DATA_WIDTH, 8, sample width in bits; two's-complement signed
LOG2_TAPS, 3, log2 of window length N (N = 8 by default); legal range 1..6

Ports:
i_clk  input  1  clock; all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_valid  input  1  i_data carries a new sample this cycle
i_data  input  DATA_WIDTH  signed input sample (from gain stage o_data)
o_valid  output  1  one-cycle pulse: o_data updated this cycle
o_data  output  DATA_WIDTH  signed averaged sample, held between pulses
o_filled  output  1  high once N samples have been accepted since reset

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high: sampled on the rising edge of i_clk while i_reset = 1.
- Reset values:
  - o_data = 0, o_valid = 0, o_filled = 0
  - running sum = 0, write pointer = 0, fill count = 0, state = FILL
  - Buffer RAM is not cleared. Unfilled slots are treated as zero via the fill count.
- Reset has priority over i_valid. A sample presented during the reset cycle is discarded.
- Accept: a sample is accepted on each rising edge with i_valid = 1 and i_reset = 0. Back-to-back acceptance every cycle is supported. There is no backpressure.
- On accept:
  - oldest = buffer[wr_ptr] in RUN; oldest = 0 in FILL.
  - sum_next = sum + i_data - oldest.
  - buffer[wr_ptr] <= i_data.
  - wr_ptr <= wr_ptr + 1, wrapping modulo N.
  - sum <= sum_next.
  - o_data <= sum_next >>> LOG2_TAPS (arithmetic shift, floor rounding toward minus infinity).
  - o_valid <= 1.
- No accept in a cycle: o_valid <= 0, o_data holds, sum and pointer hold.
- Latency: o_valid and o_data appear on the edge following the accepting edge, i.e. 1 cycle.
- Width rules:
  - Sum register is DATA_WIDTH + LOG2_TAPS bits, signed; it never overflows.
  - Quotient always fits DATA_WIDTH signed, so no saturation logic is required.
- State machine:
  - FILL: fill count increments per accept. The accept that brings the count to N moves to RUN.
  - RUN: terminal until reset. Fill count freezes.
- o_filled is registered. It rises together with the o_valid pulse for the Nth accepted sample and stays high until reset.
- During FILL, outputs are valid but biased toward zero: missing samples count as 0 and the divisor is still N.
- Reset mid-operation (either state) returns to FILL with sum 0. The next accepted sample is treated as the first.

Test Plan:
- Warm-up: reset, then 8 back-to-back accepts of 16 -> o_data 2,4,6,8,10,12,14,16 on consecutive o_valid pulses, each 1 cycle after its accept; o_filled rises with the 8th pulse.
- Step response: after the warm-up above, 8 accepts of -16 -> o_data 12,8,4,0,-4,-8,-12,-16; o_filled stays 1.
- Extremes: 8 accepts of 127 -> final o_data 127; then 8 accepts of -128 -> final o_data -128; no wrap or sign error at any intermediate step.
- Floor rounding: reset, accept -1 -> o_data = -1; then accept 7 -> sum 6, o_data = 0.
- Gapped valid: repeat the warm-up with i_valid high one cycle in three -> identical o_data sequence; o_valid is a single-cycle pulse each time; o_data holds between pulses.
- Reset mid-run: 5 accepts of 100, then i_reset = 1 for one cycle with i_valid = 1 and i_data = 50 -> next edge shows o_data = 0, o_valid = 0, o_filled = 0, and the 50 is discarded; then 8 accepts of 8 -> o_data 1..8, with o_filled rising on the 8th.
